// File: rtl/led_pkg.sv
// led_pkg: shared constants and FSM encoding for the LED request scheduler.
// Revision 1.0
`default_nettype none

package led_pkg;

  localparam int IDX_W     = 5;
  localparam int LED_COUNT = 18;
  localparam int GAP_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/led_req_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter; first request at or after i_ptr wins.
// Revision 1.0
`default_nettype none

module rr_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_winner,
  output logic               o_valid
);

  function automatic int wrap(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  // Walk from the farthest offset back to the pointer so the nearest request is written last.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[wrap(int'(i_ptr) + i)]) begin
        o_grant  = '0;
        o_grant[wrap(int'(i_ptr) + i)] = 1'b1;
        o_winner = PTR_W'(wrap(int'(i_ptr) + i));
        o_valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_req_scheduler.sv
// led_req_scheduler: shares the LED-timer request port between NUM_REQ buffered requesters.
// Optional grant counter output enabled by LED_REQ_SCHEDULER_STATS_EN.  Revision 1.0
`default_nettype none

module led_req_scheduler
  import led_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LED_COUNT  = led_pkg::LED_COUNT,
  parameter int IDX_W      = led_pkg::IDX_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         led_index,
  output logic                     led_request,
  output logic                     drop_pulse,
`ifdef LED_REQ_SCHEDULER_STATS_EN
  output logic [15:0]              grant_count,
`endif
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] r_full;
  logic [IDX_W-1:0]   r_buf [NUM_REQ];
  logic [PTR_W-1:0]   r_ptr;
  logic [GAP_W-1:0]   r_gap;
  state_t             r_state;
  state_t             w_state_nxt;

  logic [NUM_REQ-1:0] w_onehot;
  logic [PTR_W-1:0]   w_win;
  logic               w_gnt_valid;
  logic [IDX_W-1:0]   w_win_index;
  logic               w_win_ok;
  logic               w_grant;
  logic               w_issue;
  logic               w_drop;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req    (r_full),
    .i_ptr    (r_ptr),
    .o_grant  (w_onehot),
    .o_winner (w_win),
    .o_valid  (w_gnt_valid)
  );

  assign req_ready   = ~r_full & {NUM_REQ{rst}};
  assign w_win_index = r_buf[w_win];
  assign w_win_ok    = int'({1'b0, w_win_index}) < LED_COUNT;
  assign busy        = (|r_full) || (r_state != IDLE);

  // A full buffer is never ready, so load and grant-clear cannot collide on one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= '0;
      for (int r = 0; r < NUM_REQ; r++) r_buf[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          r_full[r] <= 1'b1;
          r_buf[r]  <= req_index[r*IDX_W +: IDX_W];
        end else if (w_grant && w_onehot[r]) begin
          r_full[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Leaving GAP on the edge the counter reaches 1 gives exactly GAP_CYCLES low cycles between pulses.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = (GAP_CYCLES > 1) ? GAP : IDLE;
      GAP:     if (r_gap <= GAP_W'(2)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant = (r_state == IDLE) && w_gnt_valid;
    w_issue = w_grant && w_win_ok;
    w_drop  = w_grant && !w_win_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_gap       <= '0;
      led_request <= 1'b0;
      led_index   <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      led_request <= w_issue;
      drop_pulse  <= w_drop;
      if (w_issue) led_index <= w_win_index;
      if (w_grant) r_ptr <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
      if (r_state == ISSUE)    r_gap <= GAP_W'(GAP_CYCLES);
      else if (r_state == GAP) r_gap <= r_gap - 1'b1;
    end
  end

`ifdef LED_REQ_SCHEDULER_STATS_EN
  logic [15:0] r_grant_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_grant_count <= '0;
    else if (w_issue && r_grant_count != 16'hFFFF) r_grant_count <= r_grant_count + 1'b1;
  end

  assign grant_count = r_grant_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_req_scheduler.sv
// tb_led_req_scheduler: directed self-checking bench for led_req_scheduler (default parameters).
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_led_req_scheduler;

  localparam int NR = 4;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*IW-1:0] req_index = '0;
  logic [NR-1:0]   req_ready;
  logic [IW-1:0]   led_index;
  logic            led_request;
  logic            drop_pulse;
  logic            busy;
`ifdef LED_REQ_SCHEDULER_STATS_EN
  logic [15:0]     grant_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  led_req_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_index   (req_index),
    .req_ready   (req_ready),
    .led_index   (led_index),
    .led_request (led_request),
    .drop_pulse  (drop_pulse),
`ifdef LED_REQ_SCHEDULER_STATS_EN
    .grant_count (grant_count),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idx(input int r, input logic [IW-1:0] idx);
    req_index[r*IW +: IW] = idx;
  endtask

  initial begin
    int np;
    int cyc;
    int pulses;
    int got_c [4];
    int got_i [4];
    int exp_c [4];
    int exp_i [4];
    int fair_i [6];
    int fair_e [6];
    logic busy11;
    logic busy12;

    exp_c  = '{1, 4, 7, 10};
    exp_i  = '{2, 3, 4, 5};
    fair_e = '{1, 9, 1, 9, 1, 9};

    // Reset state
    tick(); tick();
    check("rst_ready",   32'(req_ready),   32'h0);
    check("rst_request", 32'(led_request), 32'h0);
    check("rst_index",   32'(led_index),   32'h0);
    check("rst_drop",    32'(drop_pulse),  32'h0);
    check("rst_busy",    32'(busy),        32'h0);
    rst = 1'b1;
    #1;
    check("rel_ready", 32'(req_ready), 32'hF);
    tick();

    // All four requesters at once, pointer 0
    set_idx(0, 5'd2); set_idx(1, 5'd3); set_idx(2, 5'd4); set_idx(3, 5'd5);
    req_valid = 4'hF;
    tick();
    req_valid = '0;
    check("all_ready_full", 32'(req_ready), 32'h0);
    check("all_busy",       32'(busy),      32'h1);
    np = 0;
    busy11 = 1'b0;
    busy12 = 1'b1;
    for (int k = 0; k < 4; k++) begin got_c[k] = -1; got_i[k] = -1; end
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (led_request) begin
        if (np < 4) begin got_c[np] = c; got_i[np] = int'(led_index); end
        np++;
      end
      if (c == 11) busy11 = busy;
      if (c == 12) busy12 = busy;
    end
    check("all_npulse", 32'(np), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("all_cycle%0d", k), 32'(got_c[k]), 32'(exp_c[k]));
      check($sformatf("all_index%0d", k), 32'(got_i[k]), 32'(exp_i[k]));
    end
    check("all_busy_gap",  32'(busy11), 32'h1);
    check("all_busy_done", 32'(busy12), 32'h0);

    // Fairness: r0 and r2 hold valid continuously
    set_idx(0, 5'd1); set_idx(2, 5'd9);
    req_valid = 4'b0101;
    np = 0;
    cyc = 0;
    for (int k = 0; k < 6; k++) fair_i[k] = -1;
    while (np < 6 && cyc < 60) begin
      tick();
      cyc++;
      if (led_request) begin
        fair_i[np] = int'(led_index);
        np++;
      end
    end
    req_valid = '0;
    check("fair_npulse", 32'(np), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("fair_index%0d", k), 32'(fair_i[k]), 32'(fair_e[k]));
    cyc = 0;
    while (busy && cyc < 40) begin tick(); cyc++; end
    check("fair_drain_busy", 32'(busy), 32'h0);
    tick();

    // Reset in GAP with r1 and r2 buffered
    set_idx(0, 5'd6);
    req_valid = 4'b0001;
    tick();
    set_idx(1, 5'd10); set_idx(2, 5'd11);
    req_valid = 4'b0110;
    tick();
    req_valid = '0;
    check("mid_request", 32'(led_request), 32'h1);
    check("mid_index",   32'(led_index),   32'd6);
    tick();
    check("mid_busy", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_request", 32'(led_request), 32'h0);
    check("mid_rst_index",   32'(led_index),   32'h0);
    check("mid_rst_drop",    32'(drop_pulse),  32'h0);
    check("mid_rst_busy",    32'(busy),        32'h0);
    check("mid_rst_ready",   32'(req_ready),   32'h0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rel_ready", 32'(req_ready), 32'hF);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (led_request || drop_pulse) pulses++;
    end
    check("mid_no_pulse", 32'(pulses), 32'h0);
    check("mid_idle_busy", 32'(busy), 32'h0);

    // Single request from r1
    set_idx(1, 5'd7);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    check("one_ready_e0",   32'(req_ready),   32'hD);
    check("one_busy_e0",    32'(busy),        32'h1);
    check("one_request_e0", 32'(led_request), 32'h0);
    tick();
    check("one_request_e1", 32'(led_request), 32'h1);
    check("one_index_e1",   32'(led_index),   32'd7);
    check("one_ready_e1",   32'(req_ready),   32'hF);
    tick();
    check("one_request_e2", 32'(led_request), 32'h0);
    check("one_index_hold", 32'(led_index),   32'd7);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (led_request) pulses++;
    end
    check("one_no_extra", 32'(pulses), 32'h0);
    check("one_busy_end", 32'(busy),   32'h0);

    // Invalid index from r3, then a valid one
    set_idx(3, 5'd20);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    check("inv_drop",    32'(drop_pulse),  32'h1);
    check("inv_request", 32'(led_request), 32'h0);
    check("inv_ready",   32'(req_ready),   32'hF);
    check("inv_index",   32'(led_index),   32'd7);
    set_idx(3, 5'd0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    check("inv_drop_end",  32'(drop_pulse),  32'h0);
    check("inv_no_req",    32'(led_request), 32'h0);
    tick();
    check("val_request",   32'(led_request), 32'h1);
    check("val_index",     32'(led_index),   32'd0);
    tick(); tick(); tick();
    check("val_busy_end",  32'(busy), 32'h0);

`ifdef LED_REQ_SCHEDULER_STATS_EN
    check("stats_count", 32'(grant_count), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_req_scheduler.md
Name: led_req_scheduler

Overview:
- Shares the single LED-timer request port (led_index and led_request pulse) between NUM_REQ independent requesters, for example game logic, a self-test sequencer and a debug switch decoder.
- Each requester has a one-entry holding buffer.
- A round-robin arbiter selects a pending entry and a small FSM issues it as a one-cycle request pulse.
- A programmable gap separates consecutive pulses so downstream sees at most one request per GAP_CYCLES+1 cycles.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LED_COUNT, 18, number of valid LED indices; indices >= LED_COUNT are invalid.
- IDX_W, 5, index width.
- GAP_CYCLES, 2, idle cycles inserted after each issued pulse (0..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low: asserted at 0.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_index  in  NUM_REQ*IDX_W  per-requester LED index; requester r occupies bits [r*IDX_W +: IDX_W].
- req_ready  out  NUM_REQ  per-requester buffer empty; a transfer occurs when valid && ready at a clk edge.
- led_index  out  IDX_W  registered index to the LED timer block.
- led_request  out  1  registered one-cycle request pulse.
- drop_pulse  out  1  one-cycle pulse when an invalid index is discarded.
- busy  out  1  high when any buffer is full or FSM is not in IDLE.

Behaviour:
- Reset (rst=0), asynchronous:
  - all buffers empty; FSM=IDLE; RR pointer=0; gap counter=0.
  - led_request=0, led_index=0, drop_pulse=0, busy=0.
  - req_ready=0 while rst=0; after release req_ready=all ones.
  - Reset mid-issue discards all pending entries with no pulse.
- Buffer r:
  - loads req_index[r] on valid&&ready.
  - req_ready[r]=~full[r] && rst.
  - Buffer is cleared at the edge it is granted.
  - A new value cannot be accepted in the same edge the buffer clears; it is accepted next cycle.
- Arbitration:
  - Rotating priority starting at the RR pointer; the first full buffer at or after the pointer wins.
  - After each grant, pointer=(winner+1) mod NUM_REQ.
  - Pointer is unchanged when no grant occurs.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if any buffer is full, grant at this edge.
    - Valid index: led_index<=index, led_request<=1, go to ISSUE.
    - Invalid index (>=LED_COUNT): drop_pulse<=1, no led_request, no gap, stay IDLE.
  - ISSUE (led_request high for exactly this cycle): at the next edge led_request<=0.
    - If GAP_CYCLES>0, load gap counter=GAP_CYCLES and go to GAP.
    - Else go to IDLE; a back-to-back grant can occur at that edge's successor.
  - GAP: decrement each cycle; when the counter reaches 1, go to IDLE at that edge.
- led_index holds its last value after the pulse; it changes only on a new valid grant.
- Latency: transfer at edge E0 -> grant at E1 -> led_request high during the cycle after E1 (2 edges), if no contention.
- Pulse spacing: consecutive led_request pulses are separated by exactly GAP_CYCLES low cycles under continuous load; fairness is one grant per requester per NUM_REQ grants.
- Simultaneous requests from all requesters in one cycle: served in RR order from the current pointer.
- Width rules: indices compared unsigned against LED_COUNT; pointer width is clog2(NUM_REQ); gap counter is 4 bits.

Optional Feature:
- Macro: LED_REQ_SCHEDULER_STATS_EN.
- Defined:
  - adds output grant_count [15:0], reset 0.
  - increments on every issued led_request pulse; saturates at 16'hFFFF.
  - drops are not counted.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package led_pkg: IDX_W, LED_COUNT, the FSM state enum (IDLE/ISSUE/GAP), and the gap-counter width constant.
- One natural sub-module: rr_arbiter. It takes NUM_REQ request bits and the pointer, and returns a one-hot grant, the winner index and a grant-valid flag, combinationally. The pointer register stays in the top level.

Test Plan:
- Single request: r1 sends index 7 at E0 -> led_request high one cycle after E1 with led_index=7; req_ready[1] high again after E1; no other pulse.
- All four requesters present indices 2,3,4,5 in the same cycle, pointer=0, GAP_CYCLES=2 -> pulses in order 2,3,4,5, each separated by 2 low cycles; busy drops after the final GAP.
- Round-robin fairness: r0 and r2 hold valid continuously -> grants alternate r0,r2,r0,r2; neither is served twice in a row.
- Invalid index 20 from r3 -> drop_pulse for one cycle, no led_request, buffer freed; a following valid index 0 from r3 is issued normally.
- Reset mid-GAP with r1 and r2 buffers full -> all outputs return to reset values immediately; no pulse after release; req_ready=4'b1111 once rst=1.
- With LED_REQ_SCHEDULER_STATS_EN defined: 5 valid requests and 1 invalid request -> grant_count=5; force 65536 issues -> grant_count stays at 16'hFFFF.
